// File: rtl/lambda_callee_mul.sv
// Callee-side shift-and-add multiplier for the lambda call protocol.
// Accepts one call per 4-phase request/out handshake and returns the low WIDTH bits of in1*in2.
module lambda_callee_mul #(
   parameter int WIDTH      = 32,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             request,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Handshake: request is a level held by the caller until it sees out high;
   // out stays high until request drops, then both return low before the next call.
   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             out_q, out_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] mplier_shift;
   logic             last_iter;

   assign acc_step     = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mplier_shift = mplier_q >> 1;
   assign last_iter    = (count_q == CW'(WIDTH - 1)) ||
                         ((EARLY_EXIT != 0) && (mplier_shift == '0));

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
         result_q <= '0;
         out_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
         result_q <= result_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      result_d = result_q;
      out_d    = out_q;
      busy_d   = busy_q;

      case (state_q)
         IDLE: begin
            if (request) begin
               mcand_d  = in1;
               mplier_d = in2;
               acc_d    = '0;
               count_d  = '0;
               busy_d   = 1'b1;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (!request) begin
               // Caller withdrew: abandon the partial product, result keeps the last answer.
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               acc_d    = acc_step;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_shift;
               count_d  = count_q + CW'(1);
               if (last_iter) begin
                  result_d = acc_step;
                  out_d    = 1'b1;
                  busy_d   = 1'b0;
                  state_d  = DONE;
               end
            end
         end
         DONE: begin
            if (!request) begin
               out_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            out_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign out    = out_q;
   assign result = result_q;
   assign busy   = busy_q;

endmodule

// File: doc/lambda_callee_mul.md
Name: lambda_callee_mul

Overview:
- Callee-side (responder) function unit for the lambda call protocol. A caller raises request with in1/in2; this block computes in1*in2 iteratively and raises out with result.
- A function instance that a caller module instantiates and drives through request/out, one instance per call site.
- 4-phase handshake: request up, out up, request down, out down.

Parameters:
- WIDTH, 32, operand and result width in bits.
- EARLY_EXIT, 1, when 1 finish as soon as the remaining multiplier is zero; when 0 always run WIDTH iterations.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on posedge clock).
- request  input  1  call request from caller, level; held high until out seen high.
- in1  input  WIDTH  multiplicand; sampled only on call acceptance.
- in2  input  WIDTH  multiplier; sampled only on call acceptance.
- out  output  1  done/valid, registered; high while result valid and request still high.
- result  output  WIDTH  registered product, low WIDTH bits of in1*in2.
- busy  output  1  registered; high while computing (state BUSY).

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, out=0, busy=0, result=0, internal acc/mcand/mplier/count=0. Reset has priority over every other event, including mid-computation.
- State IDLE, request==1 at posedge:
  - latch mcand=in1, mplier=in2, acc=0, count=0;
  - go BUSY, busy=1.
- State IDLE, request==0: stay IDLE. result holds its last value.
- State BUSY, each posedge:
  - if request==0: abort. Go IDLE, busy=0, result unchanged, out stays 0.
  - else:
    - acc_next = acc + (mplier[0] ? mcand : 0), mod 2^WIDTH;
    - mcand <<= 1, discarding the MSB;
    - mplier >>= 1, logical;
    - count++.
  - Exit to DONE when count (pre-increment) == WIDTH-1, or when EARLY_EXIT==1 and shifted mplier==0.
  - On exit: result<=acc_next, out<=1, busy<=0.
- BUSY length n:
  - EARLY_EXIT=1: n = max(1, index of highest set bit of in2 + 1).
  - EARLY_EXIT=0: n = WIDTH.
- Latency: the request-accept edge is E0. out is first high after edge E(n), i.e. n+1 edges after acceptance.
- State DONE:
  - request==1: stay DONE, out=1, result stable. No restart, even if in1/in2 change.
  - request==0 at posedge: go IDLE, out<=0. result holds.
- Minimum call spacing: request must be seen low for at least 1 posedge (DONE→IDLE) before a new call is accepted. Back-to-back accept is therefore on the second edge after out rises, at the earliest.
- Arithmetic: unsigned, truncated to WIDTH bits; no overflow flag.
- in1/in2 changes after acceptance have no effect on the in-flight call.
- out and busy are never high in the same cycle.

Test Plan:
- Reset: hold reset=0 for 2 edges with request=1, in1=7, in2=9 -> out=0, busy=0, result=0 throughout. Release reset -> call accepted on next edge.
- Basic call: in1=3, in2=5, request=1 from edge E0 -> busy high for 3 cycles, out=1 after E3, result=15. Drop request -> out=0 after next edge, result stays 15.
- Zero and truncation cases (EARLY_EXIT=1):
  - in2=0 -> n=1, out after E1, result=0;
  - in1=0xFFFFFFFF, in2=2 -> n=2, result=0xFFFFFFFE;
  - in1=0x80000000, in2=0x80000000 -> n=32, result=0.
- Full-length mode (EARLY_EXIT=0): in1=6, in2=7 -> out after E32, result=42. Change in1/in2 during BUSY -> result still 42.
- Abort and reset mid-operation:
  - in1=5, in2=0xFFFF, drop request after E4 -> state IDLE, out never rises, result keeps the prior value;
  - repeat with reset=0 at E4 -> result=0, busy=0 on the next cycle.
- Handshake hold and re-call: keep request=1 for 10 cycles after out rises with new in1/in2 -> out stays 1, result unchanged. Drop request for 1 cycle, then raise with in1=4, in2=4 -> new call accepted, result=16 after 3 BUSY cycles.
